// File: rtl/axi_st_pkg.sv
// Shared definitions for the AXI-Stream FIFO slice.
// Holds the default widths, the beat struct and a helper that sizes a beat.

`ifndef AXI_ST_DATA_W
`define AXI_ST_DATA_W 32
`endif
`ifndef AXI_ST_SYMBOL_NUM
`define AXI_ST_SYMBOL_NUM 4
`endif
`ifndef AXI_ST_TID_W
`define AXI_ST_TID_W 4
`endif
`ifndef AXI_ST_TDEST_W
`define AXI_ST_TDEST_W 4
`endif
`ifndef AXI_ST_TUSER_W
`define AXI_ST_TUSER_W 8
`endif

package axi_st_pkg;

    localparam int AXI_ST_DATA_W_DEF     = `AXI_ST_DATA_W;
    localparam int AXI_ST_SYMBOL_NUM_DEF = `AXI_ST_SYMBOL_NUM;
    localparam int AXI_ST_TID_W_DEF      = `AXI_ST_TID_W;
    localparam int AXI_ST_TDEST_W_DEF    = `AXI_ST_TDEST_W;
    localparam int AXI_ST_TUSER_W_DEF    = `AXI_ST_TUSER_W;

    // One stored beat at the default widths; field order matches the
    // flat packing used inside the FIFO (tdata in the MSBs, tuser in the LSBs).
    typedef struct packed {
        logic [AXI_ST_DATA_W_DEF-1:0]     tdata;
        logic [AXI_ST_SYMBOL_NUM_DEF-1:0] tstrb;
        logic [AXI_ST_SYMBOL_NUM_DEF-1:0] tkeep;
        logic                             tlast;
        logic [AXI_ST_TID_W_DEF-1:0]      tid;
        logic [AXI_ST_TDEST_W_DEF-1:0]    tdest;
        logic [AXI_ST_TUSER_W_DEF-1:0]    tuser;
    } axi_st_beat_t;

    // Total bits of one beat for arbitrary field widths.
    function automatic int beat_width(input int data_w, input int symbol_num,
                                      input int tid_w, input int tdest_w,
                                      input int tuser_w);
        return data_w + 2 * symbol_num + 1 + tid_w + tdest_w + tuser_w;
    endfunction

endpackage

// File: rtl/axi_st_if.sv
// AXI-Stream bundle with master/slave views.
// Handshake: a beat transfers on a rising clk edge where tvalid && tready;
// the master holds tvalid and payload stable until that edge, and tvalid
// never depends on tready.

interface axi_st #(
    parameter int DATA_W     = `AXI_ST_DATA_W,
    parameter int SYMBOL_NUM = `AXI_ST_SYMBOL_NUM,
    parameter int TID_W      = `AXI_ST_TID_W,
    parameter int TDEST_W    = `AXI_ST_TDEST_W,
    parameter int TUSER_W    = `AXI_ST_TUSER_W
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [SYMBOL_NUM-1:0] tstrb;
    logic [SYMBOL_NUM-1:0] tkeep;
    logic                  tlast;
    logic [TID_W-1:0]      tid;
    logic [TDEST_W-1:0]    tdest;
    logic [TUSER_W-1:0]    tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi_st_fifo_ram.sv
// Beat storage: synchronous write, asynchronous read, no reset on the array.

module axi_st_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Write the incoming beat into its slot on an accepted push.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axi_st_fifo.sv
// AXI-Stream FIFO with optional store-and-forward on TLAST.
// Output beat comes straight from the storage read port (cut-through latency
// of one cycle); tready and the flags come only from registers.

module axi_st_fifo
    import axi_st_pkg::*;
#(
    parameter int DATA_W      = `AXI_ST_DATA_W,
    parameter int SYMBOL_NUM  = `AXI_ST_SYMBOL_NUM,
    parameter int TID_W       = `AXI_ST_TID_W,
    parameter int TDEST_W     = `AXI_ST_TDEST_W,
    parameter int TUSER_W     = `AXI_ST_TUSER_W,
    parameter int DEPTH       = 16,
    parameter int PACKET_MODE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_st.slave                   s,
    axi_st.master                  m,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = beat_width(DATA_W, SYMBOL_NUM, TID_W, TDEST_W, TUSER_W);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [LW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          tready_q;
    logic          push, pop, push_last, pop_last;
    logic          m_valid;
    logic [BW-1:0] wr_beat, rd_beat;

    assign push      = s.tvalid && tready_q;
    assign pop       = m_valid && m.tready;
    assign push_last = push && s.tlast;
    assign pop_last  = pop && m.tlast;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;

    // Store-and-forward holds output until a whole packet is inside, unless
    // the FIFO is full: then a packet longer than DEPTH must be let through.
    assign m_valid  = (PACKET_MODE != 0) ? (!empty && ((pkt_cnt_q != '0) || full))
                                         : !empty;
    assign m.tvalid = m_valid;
    assign s.tready = tready_q;

    assign wr_beat = {s.tdata, s.tstrb, s.tkeep, s.tlast, s.tid, s.tdest, s.tuser};
    assign {m.tdata, m.tstrb, m.tkeep, m.tlast, m.tid, m.tdest, m.tuser} = rd_beat;

    axi_st_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (BW)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (wr_beat),
        .raddr (rd_ptr_q),
        .rdata (rd_beat)
    );

    // Next occupancy and complete-packet count; simultaneous events cancel.
    always_comb begin
        level_d   = level_q;
        pkt_cnt_d = pkt_cnt_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        case ({push_last, pop_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + LW'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - LW'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    // Pointers, counters and a registered tready that looks one edge ahead.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pkt_cnt_q <= '0;
            tready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q   <= level_d;
            pkt_cnt_q <= pkt_cnt_d;
            tready_q  <= (level_d != LW'(DEPTH));
        end
    end
endmodule

// File: tb/tb_axi_st_fifo.sv
// Bench for axi_st_fifo: one cut-through and one packet-mode instance, DEPTH=4.

module tb_axi_st_fifo;
    import axi_st_pkg::*;

    localparam int BW = $bits(axi_st_beat_t);

    logic clk;
    logic rst_n;

    logic [2:0] level0, level1;
    logic       full0, full1, empty0, empty1;

    axi_st #(.DATA_W(32), .SYMBOL_NUM(4)) s0 ();
    axi_st #(.DATA_W(32), .SYMBOL_NUM(4)) m0 ();
    axi_st #(.DATA_W(32), .SYMBOL_NUM(4)) s1 ();
    axi_st #(.DATA_W(32), .SYMBOL_NUM(4)) m1 ();

    axi_st_fifo #(.DATA_W(32), .SYMBOL_NUM(4), .DEPTH(4), .PACKET_MODE(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s0),
        .m     (m0),
        .level (level0),
        .full  (full0),
        .empty (empty0)
    );

    axi_st_fifo #(.DATA_W(32), .SYMBOL_NUM(4), .DEPTH(4), .PACKET_MODE(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .s     (s1),
        .m     (m1),
        .level (level1),
        .full  (full1),
        .empty (empty1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [BW-1:0] exp0_q[$];
    logic [BW-1:0] exp1_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    function automatic logic [BW-1:0] beat(input logic [31:0] d, input logic [3:0] k,
                                           input logic l, input logic [3:0] id);
        axi_st_beat_t b;
        b.tdata = d;
        b.tstrb = k;
        b.tkeep = k;
        b.tlast = l;
        b.tid   = id;
        b.tdest = ~id;
        b.tuser = d[7:0] ^ 8'h5A;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive0(input logic [BW-1:0] b);
        int n;
        n = 0;
        {s0.tdata, s0.tstrb, s0.tkeep, s0.tlast, s0.tid, s0.tdest, s0.tuser} = b;
        s0.tvalid = 1'b1;
        @(negedge clk);
        while (!s0.tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (!s0.tready) begin
            n_fail++;
            $display("FAIL push0 timeout: tready=%0b, required 1", s0.tready);
            s0.tvalid = 1'b0;
        end else begin
            exp0_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [BW-1:0] b);
        int n;
        n = 0;
        {s1.tdata, s1.tstrb, s1.tkeep, s1.tlast, s1.tid, s1.tdest, s1.tuser} = b;
        s1.tvalid = 1'b1;
        @(negedge clk);
        while (!s1.tready && n < 50) begin
            n++;
            @(negedge clk);
        end
        n_tests++;
        if (!s1.tready) begin
            n_fail++;
            $display("FAIL push1 timeout: tready=%0b, required 1", s1.tready);
            s1.tvalid = 1'b0;
        end else begin
            exp1_q.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- monitors / scoreboard ----------------
    logic [BW-1:0] got0, want0, got1, want1;

    always @(negedge clk) begin
        if (rst_n && m0.tvalid && m0.tready) begin
            got0 = {m0.tdata, m0.tstrb, m0.tkeep, m0.tlast, m0.tid, m0.tdest, m0.tuser};
            if (exp0_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL m0 unexpected beat: got %0h, required none", got0);
            end else begin
                want0 = exp0_q.pop_front();
                check("m0 beat", 64'(got0), 64'(want0));
            end
        end
        if (rst_n && m1.tvalid && m1.tready) begin
            got1 = {m1.tdata, m1.tstrb, m1.tkeep, m1.tlast, m1.tid, m1.tdest, m1.tuser};
            if (exp1_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL m1 unexpected beat: got %0h, required none", got1);
            end else begin
                want1 = exp1_q.pop_front();
                check("m1 beat", 64'(got1), 64'(want1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] fill_vals [4];
        fill_vals = '{32'h11, 32'h22, 32'h33, 32'h44};

        rst_n = 1'b0;
        s0.tvalid = 1'b0; s0.tdata = '0; s0.tstrb = '0; s0.tkeep = '0;
        s0.tlast = 1'b0; s0.tid = '0; s0.tdest = '0; s0.tuser = '0;
        s1.tvalid = 1'b0; s1.tdata = '0; s1.tstrb = '0; s1.tkeep = '0;
        s1.tlast = 1'b0; s1.tid = '0; s1.tdest = '0; s1.tuser = '0;
        m0.tready = 1'b0;
        m1.tready = 1'b0;

        // Reset for three cycles, then release between edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst tready0", s0.tready, 1'b0);
        check("rst tvalid0", m0.tvalid, 1'b0);
        check("rst empty0", empty0, 1'b1);
        check("rst full0", full0, 1'b0);
        check("rst level1", level1, 3'd0);
        rst_n = 1'b1;
        #1;
        check("tready before first edge", s0.tready, 1'b0);
        @(posedge clk);
        #1;
        check("tready0 after release", s0.tready, 1'b1);
        check("tready1 after release", s1.tready, 1'b1);
        check("tvalid0 after release", m0.tvalid, 1'b0);
        check("level0 after release", level0, 3'd0);
        check("empty0 after release", empty0, 1'b1);

        // Fill with downstream stalled, then drain on consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            drive0(beat(fill_vals[i], 4'hF, 1'b0, 4'(i)));
        end
        s0.tvalid = 1'b0;
        check("fill full0", full0, 1'b1);
        check("fill tready0", s0.tready, 1'b0);
        check("fill level0", level0, 3'd4);
        check("fill head data", m0.tdata, 32'h11);
        m0.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("drain tvalid0", m0.tvalid, 1'b1);
        end
        @(posedge clk);
        #1;
        check("drain empty0", empty0, 1'b1);
        check("drain level0", level0, 3'd0);
        check("drain tvalid0 low", m0.tvalid, 1'b0);

        // Concurrent push/pop at level 2.
        m0.tready = 1'b0;
        drive0(beat(32'h100, 4'hF, 1'b0, 4'd0));
        drive0(beat(32'h101, 4'hF, 1'b0, 4'd1));
        check("pre-concurrent level0", level0, 3'd2);
        m0.tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive0(beat(32'h200 + 32'(i), 4'hF, 1'b0, 4'(i + 2)));
            check("concurrent level0", level0, 3'd2);
        end
        s0.tvalid = 1'b0;
        for (int i = 0; i < 20 && !empty0; i++) @(posedge clk);
        #1;
        check("concurrent drained", empty0, 1'b1);

        // Packet mode: output held until the TLAST beat is stored.
        m1.tready = 1'b1;
        drive1(beat(32'hA0, 4'hF, 1'b0, 4'd0));
        check("pkt tvalid after A0", m1.tvalid, 1'b0);
        check("pkt level after A0", level1, 3'd1);
        drive1(beat(32'hA1, 4'hF, 1'b0, 4'd1));
        check("pkt tvalid after A1", m1.tvalid, 1'b0);
        drive1(beat(32'hA2, 4'hF, 1'b1, 4'd2));
        s1.tvalid = 1'b0;
        check("pkt tvalid after A2", m1.tvalid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("pkt back-to-back tvalid", m1.tvalid, 1'b1);
            check("pkt tlast position", m1.tlast, (i == 2) ? 1'b1 : 1'b0);
        end
        @(posedge clk);
        #1;
        check("pkt empty1", empty1, 1'b1);

        // Packet longer than DEPTH: full overrides the packet hold.
        for (int i = 0; i < 3; i++) begin
            drive1(beat(32'hB0 + 32'(i), 4'h3, 1'b0, 4'(i)));
            check("ovf tvalid held", m1.tvalid, 1'b0);
        end
        drive1(beat(32'hB3, 4'h3, 1'b0, 4'd3));
        check("ovf full1", full1, 1'b1);
        check("ovf tvalid forced", m1.tvalid, 1'b1);
        drive1(beat(32'hB4, 4'h3, 1'b0, 4'd4));
        check("ovf 5th accepted level", level1, 3'd4);
        drive1(beat(32'hB5, 4'h3, 1'b1, 4'd5));
        s1.tvalid = 1'b0;
        for (int i = 0; i < 20 && !empty1; i++) @(posedge clk);
        #1;
        check("ovf drained", empty1, 1'b1);
        check("exp1 drained", 64'(exp1_q.size()), 64'd0);

        // Asynchronous reset with three beats stored.
        m0.tready = 1'b0;
        drive0(beat(32'hC0, 4'hF, 1'b0, 4'd0));
        drive0(beat(32'hC1, 4'hF, 1'b0, 4'd1));
        drive0(beat(32'hC2, 4'hF, 1'b0, 4'd2));
        s0.tvalid = 1'b0;
        check("pre-reset level0", level0, 3'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst tvalid0", m0.tvalid, 1'b0);
        check("async rst level0", level0, 3'd0);
        check("async rst full0", full0, 1'b0);
        check("async rst empty0", empty0, 1'b1);
        check("async rst tready0", s0.tready, 1'b0);
        exp0_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset tready0", s0.tready, 1'b1);
        m0.tready = 1'b1;
        drive0(beat(32'h55, 4'hF, 1'b1, 4'd7));
        s0.tvalid = 1'b0;
        check("cut-through tvalid0", m0.tvalid, 1'b1);
        check("cut-through data0", m0.tdata, 32'h55);
        repeat (3) @(posedge clk);
        #1;
        check("final empty0", empty0, 1'b1);
        check("exp0 drained", 64'(exp0_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
